seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
Reverse path of the board's hex-to-7-segment encoder. The block monitors a multiplexed, active-low 7-segment display bus (segment lines plus digit selects) and recovers the hex value shown on each digit. It filters glitches and presents one complete multi-digit frame through a valid/ready handshake. It sits on the lab self-check path, so a bench or on-chip checker can read back what the display driver is actually showing.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..8)
STABLE_CNT, 4, consecutive identical samples required before a digit is committed (2..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg_n  input  7  active-low segments; bit0=a .. bit6=g (0 shows as 7'b1000000)
dig_sel_n  input  NUM_DIGITS  active-low one-hot digit select from the display driver
out_ready  input  1  consumer accepts frame
out_valid  output  1  frame available
out_hex  output  4*NUM_DIGITS  decoded frame; digit i at [4i+3:4i]
out_err  output  NUM_DIGITS  per-digit flag: last committed pattern was not a legal hex glyph
overrun  output  1  a frame was overwritten while out_valid=1 and out_ready=0

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_hex=0, out_err=0, overrun=0, seen mask=0, stability counter=0, sync flops all ones (blank/no select).
- Input sync: seg_n and dig_sel_n pass through 2 flops; all decisions use synced values, so there is a 2-clock lag from the pins.
- Select check: exactly one synced dig_sel_n bit low = legal. Zero or more than one low: counter clears to 0 and no commit occurs.
- Stability: the counter loads 1 when (pattern, select) differs from the previous cycle's value. Otherwise it increments, saturating at STABLE_CNT.
- Commit: a digit commits on the edge where the counter reaches STABLE_CNT. It commits once per select dwell; no re-commit until the select changes.
- Decode at commit uses the exact inverse of the 16 encoder glyphs: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
- Legal glyph: the digit's working nibble is updated, its err bit cleared, and its seen bit set.
- Any other pattern, including blank 1111111: the nibble is unchanged, the err bit set, and the seen bit still set.
- Frame complete: all seen bits are 1 after a commit. The next edge loads the working nibbles and err bits into out_hex/out_err, sets out_valid=1 and clears the seen mask.
- Handshake: transfer occurs when out_valid & out_ready. out_valid falls on the next edge unless a new frame loads on that same edge; in that case out_valid stays 1 and overrun is not set.
- While out_valid=1, out_hex and out_err are stable except on overrun.
- Overrun: a frame completes while out_valid=1 and out_ready=0. New data overwrites out_hex/out_err and overrun sets (sticky). overrun clears on the next transfer.
- A select change mid-count abandons that digit's partial count; nothing is committed.
- Reset mid-frame discards partial frames and pending output.

Optional Feature:
Macro SEVEN_SEG_SCAN_DP_EN.
- Defined: adds input dp_n (1 bit, active-low, synchronised with seg_n) and output out_dp (NUM_DIGITS). dp_n is included in the stability comparison. It is captured per digit at commit and loaded into out_dp with the frame. out_dp resets to 0.
- Undefined: no dp_n/out_dp ports; decimal point is ignored.

Test Plan:
- Select digit0 with 1111001 for 10 clocks, then digits 1..3 with 0100100/0110000/0011001, 10 clocks each, out_ready=1 -> out_valid pulses one cycle with out_hex=16'h4321, out_err=0.
- Digit2 pattern held only 3 clocks (STABLE_CNT=4) before select moves on -> no commit for digit2, no frame until a later 4+ clock dwell completes.
- Digit1 driven 1111111 (blank) or 0101010 during a full frame of 8s -> out_hex[7:4] keeps its prior value, out_err=4'b0010, frame still completes.
- dig_sel_n=4'b1111, then 4'b1100, each for 20 clocks with valid glyphs -> no commits, out_valid stays 0.
- out_ready=0 across two complete frames 16'h1234 then 16'hABCD -> out_hex=16'hABCD, overrun=1; raise out_ready -> single transfer, overrun and out_valid fall next edge.
- Assert rst_n=0 mid-frame after 2 digits committed, release, scan one full frame 16'hF0E0 -> out_valid only after all 4 digits recommit, out_hex=16'hF0E0.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: watches a multiplexed active-low 7-segment bus,
// debounces each digit dwell, inverts the hex glyphs and hands out one
// complete multi-digit frame over a valid/ready handshake.
// Optional macro SEVEN_SEG_SCAN_DP_EN adds decimal-point capture (dp_n/out_dp).
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEVEN_SEG_SCAN_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   out_dp,
`endif
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_hex,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    overrun
);

`ifdef SEVEN_SEG_SCAN_DP_EN
  localparam int PAT_W = 8;
`else
  localparam int PAT_W = 7;
`endif
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

  logic [PAT_W-1:0]        w_pat_in;
  logic [PAT_W-1:0]        r_pat_s1, r_pat_s2, r_prev_pat;
  logic [NUM_DIGITS-1:0]   r_sel_s1, r_sel_s2, r_prev_sel;
  logic [7:0]              r_cnt;
  logic                    r_done;
  logic [4*NUM_DIGITS-1:0] r_work_hex;
  logic [NUM_DIGITS-1:0]   r_work_err;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic                    r_out_valid;
  logic [4*NUM_DIGITS-1:0] r_out_hex;
  logic [NUM_DIGITS-1:0]   r_out_err;
  logic                    r_overrun;
  logic [6:0]              w_seg;
  logic                    w_sel_legal, w_same, w_sel_changed, w_commit, w_load, w_xfer;
  logic [3:0]              w_dec_nib;
  logic                    w_dec_ok;

`ifdef SEVEN_SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] r_work_dp, r_out_dp;
  assign w_pat_in = {dp_n, seg_n};
  assign out_dp   = r_out_dp;
`else
  assign w_pat_in = seg_n;
`endif

  assign w_seg         = r_pat_s2[6:0];
  assign w_sel_legal   = $onehot(~r_sel_s2);
  assign w_sel_changed = (r_sel_s2 != r_prev_sel);
  assign w_same        = (r_pat_s2 == r_prev_pat) && !w_sel_changed;
  assign w_commit      = w_sel_legal && w_same && !r_done && (r_cnt == CNT_MAX - 8'd1);
  assign w_load        = &r_seen;
  assign w_xfer        = r_out_valid && out_ready;

  assign out_valid = r_out_valid;
  assign out_hex   = r_out_hex;
  assign out_err   = r_out_err;
  assign overrun   = r_overrun;

  // Two-flop synchroniser for the display bus plus a copy of last cycle's synced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat_s1   <= '1;
      r_pat_s2   <= '1;
      r_prev_pat <= '1;
      r_sel_s1   <= '1;
      r_sel_s2   <= '1;
      r_prev_sel <= '1;
    end else begin
      r_pat_s1   <= w_pat_in;
      r_pat_s2   <= r_pat_s1;
      r_prev_pat <= r_pat_s2;
      r_sel_s1   <= dig_sel_n;
      r_sel_s2   <= r_sel_s1;
      r_prev_sel <= r_sel_s2;
    end
  end

  // Stability counter; r_done blocks a second commit until the select moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (!w_sel_legal)          r_cnt <= '0;
      else if (!w_same)          r_cnt <= 8'd1;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;

      if (!w_sel_legal || w_sel_changed) r_done <= 1'b0;
      else if (w_commit)                 r_done <= 1'b1;
    end
  end

  // Inverse of the encoder's sixteen glyphs; anything else is flagged illegal.
  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_nib = 4'h0;
    case (w_seg)
      7'b1000000: w_dec_nib = 4'h0;
      7'b1111001: w_dec_nib = 4'h1;
      7'b0100100: w_dec_nib = 4'h2;
      7'b0110000: w_dec_nib = 4'h3;
      7'b0011001: w_dec_nib = 4'h4;
      7'b0010010: w_dec_nib = 4'h5;
      7'b0000010: w_dec_nib = 4'h6;
      7'b1111000: w_dec_nib = 4'h7;
      7'b0000000: w_dec_nib = 4'h8;
      7'b0011000: w_dec_nib = 4'h9;
      7'b0001000: w_dec_nib = 4'hA;
      7'b0000011: w_dec_nib = 4'hB;
      7'b1000110: w_dec_nib = 4'hC;
      7'b0100001: w_dec_nib = 4'hD;
      7'b0000110: w_dec_nib = 4'hE;
      7'b0001110: w_dec_nib = 4'hF;
      default:    w_dec_ok  = 1'b0;
    endcase
  end

  // Working frame: commits update the selected digit; a full seen mask is consumed by the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work_hex <= '0;
      r_work_err <= '0;
      r_seen     <= '0;
`ifdef SEVEN_SEG_SCAN_DP_EN
      r_work_dp  <= '0;
`endif
    end else begin
      if (w_load) r_seen <= '0;
      if (w_commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!r_sel_s2[i]) begin
            r_seen[i] <= 1'b1;
            if (w_dec_ok) begin
              r_work_hex[4*i +: 4] <= w_dec_nib;
              r_work_err[i]        <= 1'b0;
            end else begin
              r_work_err[i]        <= 1'b1;
            end
`ifdef SEVEN_SEG_SCAN_DP_EN
            r_work_dp[i] <= ~r_pat_s2[7];
`endif
          end
        end
      end
    end
  end

  // Output frame register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_hex   <= '0;
      r_out_err   <= '0;
      r_overrun   <= 1'b0;
`ifdef SEVEN_SEG_SCAN_DP_EN
      r_out_dp    <= '0;
`endif
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_hex   <= r_work_hex;
        r_out_err   <= r_work_err;
`ifdef SEVEN_SEG_SCAN_DP_EN
        r_out_dp    <= r_work_dp;
`endif
        if (r_out_valid && !out_ready) r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder (default build, 4 digits,
// STABLE_CNT=4). A small frame model pushes expected frames into a queue as
// digits are driven; a monitor pops and compares them on every transfer.
module tb_seven_seg_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 4;

   typedef struct packed {
      logic [15:0] hex;
      logic [3:0]  err;
      logic        ovr;
   } frame_t;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  dig_sel_n;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_hex;
   logic [3:0]  out_err;
   logic        overrun;

   frame_t      expQ[$];
   frame_t      monFrame;
   int          testsRun = 0;
   int          testsFailed = 0;

   logic [15:0] modelHex;
   logic [3:0]  modelErr;
   logic [3:0]  modelSeen;
   logic [3:0]  lastSel;

   seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
      .clk       (clock),
      .rst_n     (rst_n),
      .seg_n     (seg_n),
      .dig_sel_n (dig_sel_n),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_hex   (out_hex),
      .out_err   (out_err),
      .overrun   (overrun)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Forward encoder glyphs, written independently of the decoder under test.
   function automatic logic [6:0] glyphOf(input int n);
      case (n)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0011000;
         10: return 7'b0001000;
         11: return 7'b0000011;
         12: return 7'b1000110;
         13: return 7'b0100001;
         14: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Clears the model as a reset does.
   task automatic resetModel();
      modelHex  = '0;
      modelErr  = '0;
      modelSeen = '0;
      lastSel   = '1;
      expQ.delete();
   endtask

   // Drives one dwell on the bus and advances the model: a legal select held at
   // least SC clocks after a different select commits that digit.
   task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] pat, input int clocks);
      frame_t f;
      int     found;
      seg_n     = pat;
      dig_sel_n = sel;
      if ($onehot(~sel) && clocks >= SC && sel != lastSel) begin
         found = -1;
         for (int k = 0; k < 16; k++)
            if (glyphOf(k) == pat) found = k;
         for (int i = 0; i < ND; i++) begin
            if (!sel[i]) begin
               modelSeen[i] = 1'b1;
               if (found >= 0) begin
                  modelHex[4*i +: 4] = 4'(found);
                  modelErr[i]        = 1'b0;
               end else begin
                  modelErr[i] = 1'b1;
               end
            end
         end
         if (&modelSeen) begin
            f.hex = modelHex;
            f.err = modelErr;
            f.ovr = 1'b0;
            modelSeen = '0;
            if (expQ.size() > 0 && !out_ready) begin
               f.ovr = 1'b1;
               expQ[expQ.size()-1] = f;
            end else begin
               expQ.push_back(f);
            end
         end
      end
      lastSel = sel;
      repeat (clocks) @(posedge clock);
      #1;
   endtask

   // Scans a full frame, digit 0 first, from a 16-bit hex value.
   task automatic scanFrame(input logic [15:0] value, input int clocks);
      for (int d = 0; d < ND; d++)
         applyStimulus(~(4'b0001 << d), glyphOf(int'(value[4*d +: 4])), clocks);
   endtask

   // Monitor: each transfer must match the oldest expected frame.
   always @(negedge clock) begin
      if (rst_n && out_valid && out_ready) begin
         checkOutput("frameExpected", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) begin
            monFrame = expQ.pop_front();
            checkOutput("xferHex", 32'(out_hex), 32'(monFrame.hex));
            checkOutput("xferErr", 32'(out_err), 32'(monFrame.err));
            checkOutput("xferOverrun", 32'(overrun), 32'(monFrame.ovr));
         end
      end
   end

   // Main sequence of directed scenarios.
   initial begin
      rst_n     = 1'b0;
      seg_n     = '1;
      dig_sel_n = '1;
      out_ready = 1'b1;
      resetModel();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstHex", 32'(out_hex), 32'd0);
      checkOutput("rstErr", 32'(out_err), 32'd0);
      checkOutput("rstOverrun", 32'(overrun), 32'd0);
      @(posedge clock);
      #1 rst_n = 1'b1;

      // Basic frame 4321.
      scanFrame(16'h4321, 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("drainBasic", 32'(expQ.size()), 32'd0);

      // Short dwell on digit 2 must not commit; a later exact-SC dwell does.
      applyStimulus(4'b1110, glyphOf(1), 10);
      applyStimulus(4'b1101, glyphOf(2), 10);
      applyStimulus(4'b1011, glyphOf(3), 3);
      applyStimulus(4'b0111, glyphOf(4), 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("shortNoFrame", 32'(expQ.size()), 32'd0);
      checkOutput("shortValid", 32'(out_valid), 32'd0);
      applyStimulus(4'b1011, glyphOf(5), SC);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("drainShort", 32'(expQ.size()), 32'd0);

      // Illegal glyphs on digit 1 keep its nibble and raise its err bit.
      applyStimulus(4'b1110, glyphOf(8), 10);
      applyStimulus(4'b1101, 7'b1111111, 10);
      applyStimulus(4'b1011, glyphOf(8), 10);
      applyStimulus(4'b0111, glyphOf(8), 10);
      applyStimulus(4'b1110, glyphOf(8), 10);
      applyStimulus(4'b1101, 7'b0101010, 10);
      applyStimulus(4'b1011, glyphOf(8), 10);
      applyStimulus(4'b0111, glyphOf(8), 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("drainErr", 32'(expQ.size()), 32'd0);

      // No select and a two-hot select never commit.
      applyStimulus(4'b1111, glyphOf(5), 20);
      applyStimulus(4'b1100, glyphOf(6), 20);
      checkOutput("badSelValid", 32'(out_valid), 32'd0);
      applyStimulus(4'b1011, glyphOf(7), 10);
      applyStimulus(4'b0111, glyphOf(9), 10);
      applyStimulus(4'b1110, glyphOf(10), 10);
      applyStimulus(4'b1101, glyphOf(11), 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("drainBadSel", 32'(expQ.size()), 32'd0);

      // Two frames with the consumer stalled: second overwrites, overrun sticks.
      out_ready = 1'b0;
      scanFrame(16'h1234, 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("ovrFirstHex", 32'(out_hex), 32'h1234);
      checkOutput("ovrFirstFlag", 32'(overrun), 32'd0);
      scanFrame(16'hABCD, 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("ovrValid", 32'(out_valid), 32'd1);
      checkOutput("ovrHex", 32'(out_hex), 32'hABCD);
      checkOutput("ovrFlag", 32'(overrun), 32'd1);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("ovrValidFall", 32'(out_valid), 32'd0);
      checkOutput("ovrFlagFall", 32'(overrun), 32'd0);
      checkOutput("drainOvr", 32'(expQ.size()), 32'd0);

      // Reset after two commits discards the partial frame.
      applyStimulus(4'b1110, glyphOf(7), 10);
      applyStimulus(4'b1101, glyphOf(9), 10);
      rst_n     = 1'b0;
      seg_n     = '1;
      dig_sel_n = '1;
      resetModel();
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("midRstValid", 32'(out_valid), 32'd0);
      checkOutput("midRstHex", 32'(out_hex), 32'd0);
      @(posedge clock);
      #1 rst_n = 1'b1;
      applyStimulus(4'b1110, glyphOf(0), 10);
      applyStimulus(4'b1101, glyphOf(14), 10);
      applyStimulus(4'b1011, glyphOf(0), 10);
      checkOutput("partialValid", 32'(out_valid), 32'd0);
      applyStimulus(4'b0111, glyphOf(15), 10);
      applyStimulus(4'hF, 7'h7F, 8);
      checkOutput("drainRst", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
